// File: rtl/sram_sim_pipelined.sv
// Behavioural SRAM model for chip-level simulation: valid/ready requests, RD_LAT-deep
// read pipeline, post-reset zero-fill sequencer and out-of-range access flagging.
module sram_sim_pipelined #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 16384,
  parameter int RD_LAT    = 2,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_src,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] sdram_data,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              wr_err,
  output logic              init_done
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT_U    = RD_LAT;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  localparam state_t RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_idle;
  logic              r_wr_err;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_pv  [RD_LAT];
  logic              r_pe  [RD_LAT];
  logic [DATA_W-1:0] r_pd  [RD_LAT];

  logic              w_accept;
  logic              w_rd_acc;
  logic              w_in_range;
  logic              w_wr_en;
  logic              w_init_we;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_idle  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= (w_state_nxt == ST_IDLE);
      if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_cnt == LAST_IDX) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept   = req_valid && r_idle;
    w_rd_acc   = w_accept && !req_write;
    w_in_range = ({1'b0, addr} < DEPTH_A);
    w_idx      = addr[IDX_W-1:0];
    w_wdata    = req_src ? sdram_data : wb_data;
    w_wr_en    = w_accept && req_write && w_in_range;
    // Gated by n_rst so clock edges seen while reset is held never touch memory.
    w_init_we  = (r_state == ST_INIT) && n_rst;
    w_rdata    = w_in_range ? r_mem[w_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (w_init_we)    r_mem[r_cnt] <= '0;
    else if (w_wr_en) r_mem[w_idx] <= w_wdata;
  end

  // Data words advance only behind a valid entry, so rd_data holds across bubbles.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < LAT_U; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 1'b0;
        r_pd[i] <= '0;
      end
      r_wr_err <= 1'b0;
    end else begin
      r_pv[0] <= w_rd_acc;
      r_pe[0] <= w_rd_acc && !w_in_range;
      if (w_rd_acc) r_pd[0] <= w_rdata;
      for (int unsigned i = 1; i < LAT_U; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
      r_wr_err <= w_accept && req_write && !w_in_range;
    end
  end

  always_comb begin
    req_ready = r_idle;
    init_done = r_idle;
    rd_valid  = r_pv[RD_LAT-1];
    rd_err    = r_pe[RD_LAT-1];
    rd_data   = r_pd[RD_LAT-1];
    wr_err    = r_wr_err;
  end

endmodule

// File: doc/sram_sim_pipelined.md
Name: sram_sim_pipelined

Overview:
Parametrised behavioural SRAM model for chip-level simulation. It is the successor of the single-port cache model, and is not synthesised for the FPGA. It adds:
- a valid/ready request handshake
- a configurable read-latency pipeline
- a post-reset zero-initialisation sequencer
- out-of-range address detection

The write source is still muxed between the SDRAM buffer (row cache) and the window buffer (output array).

Parameters:
DATA_W, 32, word width in bits
ADDR_W, 14, address width in bits
DEPTH, 16384, number of words; legal range 2..2^ADDR_W
RD_LAT, 2, cycles from read acceptance to rd_valid; legal range 1..8
INIT_ZERO, 1, 1 = clear all words after reset; 0 = skip init and go straight to IDLE

Ports:
clk  in  1  system clock, all logic on posedge
n_rst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  model can accept a request this cycle
req_write  in  1  1 = write, 0 = read
req_src  in  1  write data source: 1 = sdram_data, 0 = wb_data
addr  in  ADDR_W  word address
sdram_data  in  DATA_W  write data from the SDRAM buffer
wb_data  in  DATA_W  write data from the window buffer
rd_data  out  DATA_W  read data, qualified by rd_valid
rd_valid  out  1  one-cycle pulse per completed read
rd_err  out  1  read was out of range; aligned with rd_valid
wr_err  out  1  one-cycle pulse, the cycle after an out-of-range write is accepted
init_done  out  1  high once initialisation is complete

Behaviour:
- Reset (n_rst low, asynchronous): all outputs 0; read pipeline flushed; init counter = 0; state = INIT if INIT_ZERO, else IDLE. Memory contents are not touched by reset itself.
- Reset asserted mid-init or mid-read: in-flight reads are discarded (no rd_valid) and init restarts from word 0.
- FSM states:
  - INIT: each cycle, write 0 to mem[cnt] and increment cnt. After writing word DEPTH-1, go to IDLE. INIT lasts exactly DEPTH cycles.
  - IDLE: permanent operating state.
- init_done: 1 in IDLE, registered.
- req_ready: 1 in IDLE, 0 in INIT; it never depends on req_valid.
- A request is accepted on a posedge where req_valid && req_ready.
- Accepted write, addr < DEPTH: mem[addr] <= (req_src ? sdram_data : wb_data) at that edge.
- Accepted write, addr >= DEPTH: memory unchanged; wr_err = 1 for the next cycle only.
- Accepted read at edge N, result at edge N+RD_LAT:
  - rd_valid = 1 for one cycle.
  - rd_data = mem[addr] sampled at edge N; it reflects all writes accepted before edge N.
  - If addr >= DEPTH: rd_data = 0 and rd_err = 1.
- Pipeline: an RD_LAT-stage shift register of {valid, err, data}. One read may be accepted per cycle, so back-to-back reads produce back-to-back rd_valid pulses in order.
- Write followed by a read of the same address on the next accepted edge: the read returns the new data.
- req_src is ignored for reads.
- Reads and writes interleave freely; no request is ever dropped in IDLE.
- When rd_valid = 0: rd_data holds its last value and rd_err = 0.
- Memory array size is DEPTH words. There is no address wrap: out-of-range accesses are flagged, never aliased.

Test Plan:
- Init, DEPTH=16, RD_LAT=2, INIT_ZERO=1: release n_rst. Required: req_ready=0 for exactly 16 cycles, then init_done=1 and req_ready=1. Read addr 5 returns 0x00000000 with rd_valid exactly 2 cycles after acceptance.
- Source mux: write addr 3 with req_src=1, sdram_data=0xDEADBEEF; write addr 4 with req_src=0, wb_data=0x12345678. Read 3 then 4 back-to-back. Required: rd_valid pulses on consecutive cycles carrying 0xDEADBEEF then 0x12345678.
- Read-after-write: write 0xA5A5A5A5 to addr 7, then read addr 7 on the next cycle. Required: 0xA5A5A5A5 returned.
- Out-of-range: DEPTH=16, ADDR_W=5.
  - Write addr 20. Required: wr_err pulses for one cycle and mem[4] is unchanged.
  - Read addr 20. Required: rd_valid=1, rd_err=1, rd_data=0.
- Reset mid-operation: issue 2 reads, then assert n_rst before they complete. Required: no rd_valid appears, and INIT restarts from word 0 (16 cycles of req_ready=0).
- Latency sweep, RD_LAT=1 and RD_LAT=4: a stream of 8 reads to addr 0..7. Required: 8 in-order rd_valid pulses starting exactly RD_LAT cycles after the first acceptance.
